calc_input_ctrl: RTL and testbench

CALC_INPUT_CTRL -- requirements
Module: calc_input_ctrl

---
 rtl/calc_pkg.sv | 21 ++
 rtl/button_debouncer.sv | 56 +++++
 rtl/calc_input_ctrl.sv | 72 +++++++
 tb/tb_calc_input_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator entry path: the stage encoding driven to the
// input register and a helper that expands a stage to its one-hot LED pattern.
package calc_pkg;

  typedef enum logic [1:0] {
    STAGE_A      = 2'd0,
    STAGE_B      = 2'd1,
    STAGE_OP     = 2'd2,
    STAGE_RESULT = 2'd3
  } stage_t;

  localparam int DEBOUNCE_DEFAULT = 4;

  function automatic logic [3:0] stage_onehot(input stage_t s);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-sample debouncer for one raw push-button;
// emits a single-cycle pulse when the debounced level rises.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic LEVEL,
  output logic PRESS_PULSE
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter tracks consecutive samples disagreeing with the accepted level; it
  // clears on any agreeing sample and on acceptance, so it never needs to wrap.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= BTN_RAW;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LEVEL       = level_q;
  assign PRESS_PULSE = pulse_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// Entry-stage controller: two debounced buttons step a four-stage sequence
// (A, B, OP, RESULT); ENTER advances with wrap, UNDO retreats and saturates at A.
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_ENTER,
  input  logic       BTN_UNDO,
  output logic [1:0] STATE,
  output logic [3:0] LED_STAGE,
  output logic       RESULT_VALID
);

  logic   enter_lvl, enter_evt;
  logic   undo_lvl, undo_evt;
  stage_t state_q, state_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .CLK         (CLK),
    .RESET       (RESET),
    .BTN_RAW     (BTN_ENTER),
    .LEVEL       (enter_lvl),
    .PRESS_PULSE (enter_evt)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo_db (
    .CLK         (CLK),
    .RESET       (RESET),
    .BTN_RAW     (BTN_UNDO),
    .LEVEL       (undo_lvl),
    .PRESS_PULSE (undo_evt)
  );

  // Simultaneous ENTER and UNDO events cancel each other.
  always_comb begin
    state_d = state_q;
    if (enter_evt && !undo_evt) begin
      case (state_q)
        STAGE_A:  state_d = STAGE_B;
        STAGE_B:  state_d = STAGE_OP;
        STAGE_OP: state_d = STAGE_RESULT;
        default:  state_d = STAGE_A;
      endcase
    end else if (undo_evt && !enter_evt) begin
      case (state_q)
        STAGE_B:      state_d = STAGE_A;
        STAGE_OP:     state_d = STAGE_B;
        STAGE_RESULT: state_d = STAGE_OP;
        default:      state_d = STAGE_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= STAGE_A;
    end else begin
      state_q <= state_d;
    end
  end

  assign STATE        = state_q;
  assign LED_STAGE    = stage_onehot(state_q);
  assign RESULT_VALID = (state_q == STAGE_RESULT);

  ap_enter_pulse_level: assert property (@(posedge CLK) disable iff (!RESET) enter_evt |-> enter_lvl);
  ap_undo_pulse_level:  assert property (@(posedge CLK) disable iff (!RESET) undo_evt  |-> undo_lvl);

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Bench for calc_input_ctrl: directed scenarios plus randomized button activity,
// checked every cycle against a sample-history reference model.
module tb_calc_input_ctrl;

  localparam int D = 4;

  logic       CLK;
  logic       RESET;
  logic       BTN_ENTER;
  logic       BTN_UNDO;
  logic [1:0] STATE;
  logic [3:0] LED_STAGE;
  logic       RESULT_VALID;

  int n_checks = 0;
  int n_errors = 0;

  calc_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BTN_ENTER    (BTN_ENTER),
    .BTN_UNDO     (BTN_UNDO),
    .STATE        (STATE),
    .LED_STAGE    (LED_STAGE),
    .RESULT_VALID (RESULT_VALID)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button is accepted at a new level once its last D synchronized samples
  // (raw value two edges ago) all show that level; a rise gives one event,
  // which moves the stage on the following edge.
  int m_state;
  bit r1[2], r2[2], run_val[2], level[2], pend[2];
  int run[2];

  task automatic model_step();
    bit raw[2];
    bit s;
    if (!RESET) begin
      m_state = 0;
      for (int b = 0; b < 2; b++) begin
        r1[b] = 0; r2[b] = 0; run_val[b] = 0; level[b] = 0; pend[b] = 0; run[b] = 0;
      end
    end else begin
      if (pend[0] && !pend[1]) m_state = (m_state + 1) % 4;
      else if (pend[1] && !pend[0]) m_state = (m_state == 0) ? 0 : m_state - 1;
      raw[0] = BTN_ENTER;
      raw[1] = BTN_UNDO;
      for (int b = 0; b < 2; b++) begin
        s = r2[b];
        r2[b] = r1[b];
        r1[b] = raw[b];
        if (s == run_val[b]) begin
          if (run[b] < 1000) run[b]++;
        end else begin
          run_val[b] = s;
          run[b] = 1;
        end
        pend[b] = 0;
        if (run_val[b] != level[b] && run[b] >= D) begin
          level[b] = run_val[b];
          pend[b] = run_val[b];
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge RESET);
      model_step();
    end
  end

  // Every cycle outside reset: all three outputs against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1) begin
        check_eq("cyc_state", {6'd0, STATE}, 8'(m_state));
        check_eq("cyc_led", {4'd0, LED_STAGE}, 8'(4'b0001 << m_state));
        check_eq("cyc_valid", {7'd0, RESULT_VALID}, {7'd0, (m_state == 3)});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    BTN_ENTER = 1'b0;
    BTN_UNDO  = 1'b0;
    RESET = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
  endtask

  task automatic press(input bit e, input bit u, input int hold);
    BTN_ENTER = e;
    BTN_UNDO  = u;
    repeat (hold) tick();
    BTN_ENTER = 1'b0;
    BTN_UNDO  = 1'b0;
    repeat (D + 4) tick();
  endtask

  task automatic check_outputs(input string tag, input int st);
    check_eq({tag, "_state"}, {6'd0, STATE}, 8'(st));
    check_eq({tag, "_led"}, {4'd0, LED_STAGE}, 8'(4'b0001 << st));
    check_eq({tag, "_valid"}, {7'd0, RESULT_VALID}, {7'd0, (st == 3)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq[4];
    int op;
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0;
    RESET = 1'b0;
    BTN_ENTER = 1'b0;
    BTN_UNDO  = 1'b0;
    repeat (2) tick();
    check_outputs("reset", 0);

    // Press held from edge 10 changes the stage at edge 16 and only once.
    RESET = 1'b1;
    repeat (9) tick();
    BTN_ENTER = 1'b1;
    repeat (6) tick();
    check_eq("latency_before", {6'd0, STATE}, 8'd0);
    tick();
    check_eq("latency_at16", {6'd0, STATE}, 8'd1);
    check_eq("latency_led", {4'd0, LED_STAGE}, 8'b0010);
    repeat (13) tick();
    check_eq("held_no_repeat", {6'd0, STATE}, 8'd1);
    BTN_ENTER = 1'b0;
    repeat (D + 4) tick();
    check_eq("release_no_event", {6'd0, STATE}, 8'd1);

    // Four ENTER presses walk the full ring.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, D + 3);
      check_outputs($sformatf("ring%0d", i), seq[i]);
    end

    // UNDO saturates at A, otherwise steps back.
    do_reset();
    press(1'b0, 1'b1, D + 3);
    check_eq("undo_in_a", {6'd0, STATE}, 8'd0);
    press(1'b1, 1'b0, D + 3);
    press(1'b1, 1'b0, D + 3);
    press(1'b0, 1'b1, D + 3);
    check_eq("enter_enter_undo", {6'd0, STATE}, 8'd1);

    // Short pulse and fast toggling are rejected.
    press(1'b1, 1'b0, 3);
    check_eq("glitch3", {6'd0, STATE}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      BTN_ENTER = ~BTN_ENTER;
      repeat (2) tick();
    end
    BTN_ENTER = 1'b0;
    repeat (D + 4) tick();
    check_eq("toggle2", {6'd0, STATE}, 8'd1);

    // Both buttons rising together cancel.
    press(1'b1, 1'b1, D + 6);
    check_eq("both_cancel", {6'd0, STATE}, 8'd1);

    // Asynchronous reset in the middle of a debounce, button kept held.
    press(1'b1, 1'b0, D + 3);
    check_eq("pre_reset_state", {6'd0, STATE}, 8'd2);
    BTN_ENTER = 1'b1;
    repeat (3) tick();
    #2 RESET = 1'b0;
    #1;
    check_outputs("async_reset", 0);
    repeat (2) tick();
    #3 RESET = 1'b1;
    repeat (D + 2) tick();
    check_eq("rerelease_before", {6'd0, STATE}, 8'd0);
    tick();
    check_eq("rerelease_at", {6'd0, STATE}, 8'd1);
    BTN_ENTER = 1'b0;
    repeat (D + 4) tick();

    // Randomized activity, model checks every cycle.
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: press(1'b1, 1'b0, $urandom_range(1, 10));
        1: press(1'b0, 1'b1, $urandom_range(1, 10));
        2: press(1'b1, 1'b1, $urandom_range(1, 10));
        3: begin
          for (int k = 0; k < 8; k++) begin
            BTN_ENTER = 1'($urandom_range(0, 1));
            BTN_UNDO  = 1'($urandom_range(0, 1));
            tick();
          end
          press(1'b0, 1'b0, 1);
        end
        default: repeat ($urandom_range(1, 5)) tick();
      endcase
      check_eq("rand_state", {6'd0, STATE}, 8'(m_state));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
